// File: rtl/sevenseg_pkg.sv
// Shared constants, types and the hex-to-segment decoder for the
// multiplexed common-anode 7-segment display stage (sevenseg_scan).
package sevenseg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [6:0] SEG_OFF    = 7'h7F;  // all segments dark (active-low)

  typedef logic [1:0] digit_idx_t;

  // Registered display outputs travel together: anodes plus segments.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } disp_t;

  // Segment patterns {g,f,e,d,c,b,a}, active-low, indexed by hex value.
  localparam logic [6:0] HEX2SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    return HEX2SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/sevenseg_scan_if.sv
// Display-stage bus: the word to show plus edit hints from the operand
// register, and the active-low anode/segment/decimal-point lines.
// master = upstream register side, slave = sevenseg_scan.
interface sevenseg_scan_if;

  logic [15:0] value;
  logic        edit;
  logic [1:0]  sel;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;

  modport master (
    output value, edit, sel,
    input  seg, an, dp
  );

  modport slave (
    input  value, edit, sel,
    output seg, an, dp
  );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and wraps, asserting tick
// combinationally during the cycle the count sits at DIV-1.
// Asynchronous active-high reset clears the count.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // DIV = 1 still needs a 1-bit counter so the declarations stay legal.
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: wrap on the terminal value, otherwise increment.
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Count register with asynchronous reset.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: shows a 16-bit word as four hex digits on a multiplexed,
// common-anode 7-segment display. Digits are scanned by a refresh
// prescaler; each digit change is preceded by one all-anodes-off cycle to
// stop ghosting. The word is snapshotted once per frame so a frame never
// mixes old and new digits. Nibble 0 is the rightmost digit (an[0]).
//
// Optional feature, macro SEVENSEG_BLINK_EN: while edit is high the digit
// selected by sel blinks at BLINK_HZ. Without the macro no blink counter is
// built and edit/sel are ignored (ports kept for a stable top level).
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic           clk,
  input  logic           reset,
  sevenseg_scan_if.slave bus
);

  localparam int DIV  = CLK_HZ / REFRESH_HZ;       // cycles per digit slot
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);   // cycles per blink half-period

  localparam disp_t DISP_RESET = '{an: 4'hF, seg: SEG_OFF};

  logic       tick;
  logic       hide_digit;   // blank the segments of the digit about to light

  digit_idx_t  idx_q,    idx_d;
  logic [15:0] shadow_q, shadow_d;
  logic        blank_q,  blank_d;
  disp_t       disp_q,   disp_d;

  tick_gen #(.DIV(DIV)) u_refresh (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef SEVENSEG_BLINK_EN
  logic blink_tick;
  logic blink_on_q, blink_on_d;

  tick_gen #(.DIV(BDIV)) u_blink (
    .clk   (clk),
    .reset (reset),
    .tick  (blink_tick)
  );

  // Blink phase flips every time the blink counter wraps.
  always_comb begin
    blink_on_d = blink_tick ? ~blink_on_q : blink_on_q;
  end

  // Blink phase register; starts in the visible phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) blink_on_q <= 1'b1;
    else       blink_on_q <= blink_on_d;
  end

  // Sampled at the lit edge: idx_q already names the digit being lit.
  assign hide_digit = bus.edit && !blink_on_q && (idx_q == bus.sel);
`else
  logic unused_blink;
  assign unused_blink = ^{bus.edit, bus.sel, 1'(BDIV)};
  assign hide_digit   = 1'b0;
`endif

  // Scan sequencing: tick blanks and advances, the following edge lights.
  // NOTE: every variable gets its hold value first, so no path through
  // the branches leaves one unassigned and no latch is inferred.
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    blank_d  = blank_q;
    disp_d   = disp_q;

    if (tick) begin
      idx_d     = idx_q + 1'b1;           // 3 wraps to 0 in two bits
      disp_d.an = 4'hF;
      blank_d   = 1'b1;
      if (idx_q == digit_idx_t'(NUM_DIGITS - 1)) shadow_d = bus.value;
    end else if (blank_q) begin
      disp_d.an  = ~(4'b0001 << idx_q);
      disp_d.seg = hide_digit ? SEG_OFF : hex2seg(shadow_q[4*idx_q +: 4]);
      blank_d    = 1'b0;
    end
  end

  // Scan state and registered outputs, all cleared asynchronously.
  // NOTE: the shadow word is an ordinary register, not a RAM, so it is
  // reset along with the rest; a memory array would be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= digit_idx_t'(NUM_DIGITS - 1);
      shadow_q <= 16'h0000;
      blank_q  <= 1'b0;
      disp_q   <= DISP_RESET;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      blank_q  <= blank_d;
      disp_q   <= disp_d;
    end
  end

  assign bus.seg = disp_q.seg;
  assign bus.an  = disp_q.an;
  assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan with CLK_HZ=16, REFRESH_HZ=4,
// BLINK_HZ=1 (DIV=4, BDIV=8). Honours SEVENSEG_BLINK_EN like the RTL.
// The reference model derives the display from the edge count since reset
// release and the recorded input history.
module tb_sevenseg_scan;

  localparam int HMAX = 1024;
`ifdef SEVENSEG_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  localparam logic [6:0] SEG_REF [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk   = 1'b0;
  logic reset = 1'b1;

  sevenseg_scan_if bus ();

  sevenseg_scan #(
    .CLK_HZ     (16),
    .REFRESH_HZ (4),
    .BLINK_HZ   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Edge count since reset release plus the inputs seen at each edge.
  int          k = 0;
  logic [15:0] h_val  [HMAX];
  logic        h_edit [HMAX];
  logic [1:0]  h_sel  [HMAX];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= 0;
    end else if (k < HMAX - 1) begin
      k             <= k + 1;
      h_val[k + 1]  <= bus.value;
      h_edit[k + 1] <= bus.edit;
      h_sel[k + 1]  <= bus.sel;
    end
  end

  // Expected {an, seg} after edge kk. Edges 1..4 are dark; then each
  // 4-edge slot lights digit d on its first edge, holds two more, and
  // blanks the anodes on its fourth. Frame f shows the word captured at
  // edge 4+16f. Blink phase toggles every 8 edges, starting visible.
  function automatic logic [10:0] model(input int kk);
    int          t, kl, d;
    logic [15:0] v;
    logic [3:0]  nib;
    logic [6:0]  s;
    logic [3:0]  a;
    if (kk <= 4) return {4'hF, 7'h7F};
    t   = kk - 5;
    d   = (t / 4) % 4;
    kl  = 5 + 4 * (t / 4);
    v   = h_val[4 + 16 * (t / 16)];
    nib = v[4*d +: 4];
    s   = SEG_REF[nib];
    if (BLINK_EN && h_edit[kl] && (((kl - 1) / 8) % 2 == 1) && (h_sel[kl] == d[1:0]))
      s = 7'h7F;
    a = (t % 4 == 3) ? 4'hF : ~(4'b0001 << d);
    return {a, s};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    @(negedge clk);
    n_cmp++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", bus.seg); end
    n_cmp++; if (bus.an  !== 4'hF)  begin n_err++; $display("FAIL reset_an got %h want f", bus.an); end
    n_cmp++; if (bus.dp  !== 1'b1)  begin n_err++; $display("FAIL reset_dp got %b want 1", bus.dp); end
    bus.value = 16'h1234; bus.edit = 1'b0; bus.sel = 2'd0;
    reset = 1'b0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      exp = model(k);
      n_cmp++;
      if ({bus.an, bus.seg} !== exp) begin
        n_err++;
        $display("FAIL scan1234 k=%0d an/seg got %h/%h want %h/%h", k, bus.an, bus.seg, exp[10:7], exp[6:0]);
      end
      if (k == 5 || k == 9 || k == 13 || k == 17) begin
        n_cmp++;
        if ({bus.an, bus.seg} !== ((k == 5) ? {4'hE, 7'h19} : (k == 9) ? {4'hD, 7'h30} :
                                   (k == 13) ? {4'hB, 7'h24} : {4'h7, 7'h79})) begin
          n_err++;
          $display("FAIL order1234 k=%0d an/seg got %h/%h", k, bus.an, bus.seg);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    logic [10:0] exp;
    bus.value = 16'hA5F0; bus.edit = 1'b0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp = model(k);
      n_cmp++;
      if ({bus.an, bus.seg} !== exp) begin
        n_err++;
        $display("FAIL snapshot k=%0d an/seg got %h/%h want %h/%h", k, bus.an, bus.seg, exp[10:7], exp[6:0]);
      end
      if (k == 17) begin
        n_cmp++;
        if ({bus.an, bus.seg} !== {4'h7, 7'h08}) begin
          n_err++; $display("FAIL snapshot_old_digit3 got %h/%h want 7/08", bus.an, bus.seg);
        end
      end
      if (k == 21 || k == 25 || k == 29 || k == 33) begin
        n_cmp++;
        if (bus.seg !== 7'h40) begin
          n_err++; $display("FAIL snapshot_new_frame k=%0d seg got %h want 40", k, bus.seg);
        end
      end
      if (k == 13) bus.value = 16'h0000;   // change while digit 2 is lit
    end
  endtask

  task automatic test_decode_sweep();
    logic [10:0] exp;
    bus.value = 16'h89EF; bus.edit = 1'b0;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      exp = model(k);
      n_cmp++;
      if ({bus.an, bus.seg} !== exp) begin
        n_err++;
        $display("FAIL decode k=%0d an/seg got %h/%h want %h/%h", k, bus.an, bus.seg, exp[10:7], exp[6:0]);
      end
      if (k == 5 || k == 9 || k == 13 || k == 17) begin
        n_cmp++;
        if (bus.seg !== ((k == 5) ? 7'h0E : (k == 9) ? 7'h06 : (k == 13) ? 7'h10 : 7'h00)) begin
          n_err++; $display("FAIL decode_const k=%0d seg got %h", k, bus.seg);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [10:0] exp;
    bus.value = 16'($urandom); bus.edit = 1'b0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      exp = model(k);
      n_cmp++;
      if ({bus.an, bus.seg} !== exp) begin
        n_err++;
        $display("FAIL pre_reset k=%0d an/seg got %h/%h want %h/%h", k, bus.an, bus.seg, exp[10:7], exp[6:0]);
      end
    end
    #2 reset = 1'b1;                       // digit 1 lit, no clock edge until +5
    #1;
    n_cmp++; if (bus.an  !== 4'hF)  begin n_err++; $display("FAIL async_an got %h want f", bus.an); end
    n_cmp++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL async_seg got %h want 7f", bus.seg); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = model(k);
      n_cmp++;
      if ({bus.an, bus.seg} !== exp) begin
        n_err++;
        $display("FAIL post_reset k=%0d an/seg got %h/%h want %h/%h", k, bus.an, bus.seg, exp[10:7], exp[6:0]);
      end
      if (k == 5) begin
        n_cmp++;
        if (bus.an !== 4'hE) begin n_err++; $display("FAIL post_reset_first got an %h want e", bus.an); end
      end
    end
  endtask

  task automatic test_blink();
    logic [10:0] exp;
    bus.value = 16'h8888; bus.edit = 1'b1; bus.sel = 2'd2;
    apply_reset();
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      exp = model(k);
      n_cmp++;
      if ({bus.an, bus.seg} !== exp) begin
        n_err++;
        $display("FAIL blink k=%0d an/seg got %h/%h want %h/%h", k, bus.an, bus.seg, exp[10:7], exp[6:0]);
      end
      if (k == 13 || k == 29) begin
        n_cmp++;
        if ({bus.an, bus.seg} !== {4'hB, (BLINK_EN ? 7'h7F : 7'h00)}) begin
          n_err++; $display("FAIL blink_sel_digit k=%0d an/seg got %h/%h", k, bus.an, bus.seg);
        end
      end
      if (k == 5 || k == 9 || k == 17) begin
        n_cmp++;
        if (bus.seg !== 7'h00) begin n_err++; $display("FAIL blink_other k=%0d seg got %h want 00", k, bus.seg); end
      end
      if (k == 36) bus.edit = 1'b0;        // next frame: no digit may blank
      if (k >= 41 && (k - 41) % 4 == 0) begin
        n_cmp++;
        if (bus.seg !== 7'h00) begin n_err++; $display("FAIL blink_edit_off k=%0d seg got %h want 00", k, bus.seg); end
      end
    end
  endtask

  task automatic test_random();
    logic [10:0] exp;
    for (int r = 0; r < 4; r++) begin
      bus.value = 16'($urandom); bus.edit = 1'($urandom); bus.sel = 2'($urandom);
      apply_reset();
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        exp = model(k);
        n_cmp++;
        if ({bus.an, bus.seg, bus.dp} !== {exp, 1'b1}) begin
          n_err++;
          $display("FAIL random r=%0d k=%0d an/seg/dp got %h/%h/%b want %h/%h/1",
                   r, k, bus.an, bus.seg, bus.dp, exp[10:7], exp[6:0]);
        end
        if ($urandom_range(7) == 0) bus.value = 16'($urandom);
        if ($urandom_range(15) == 0) begin
          bus.edit = 1'($urandom);
          bus.sel  = 2'($urandom);
        end
      end
    end
  endtask

  initial begin
    bus.value = 16'h0000;
    bus.edit  = 1'b0;
    bus.sel   = 2'd0;
    test_reset();
    test_snapshot();
    test_decode_sweep();
    test_async_reset();
    test_blink();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Downstream display stage for the 16-bit operand register. Takes the register's `x_out` word and shows it as four hex digits on the board's multiplexed, common-anode 7-segment display. It time-multiplexes the digits with a refresh prescaler and blanks the anodes between digits to prevent ghosting. All four digits of a frame come from one snapshot of the input, so a frame never shows a mix of old and new digits.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency.
- `REFRESH_HZ`, default 1000: per-digit switch rate. `DIV = CLK_HZ/REFRESH_HZ` must be ≥ 2.
- `BLINK_HZ`, default 2: blink rate, used only with `SEVENSEG_BLINK_EN`. `BDIV = CLK_HZ/(2*BLINK_HZ)` must be ≥ 1.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high. The clock is `clk`.
- `value` in 16: word to display. Nibble 0 is the rightmost digit.
- `edit` in 1: high while the upstream register is in nibble-edit mode.
- `sel` in 2: index of the nibble being edited.
- `seg` out 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `an` out 4: digit anodes, active-low, one-cold.
- `dp` out 1: decimal point, active-low. It is always 1 (off).

## Operation
- Reset values:
  - `seg` = 7'h7F, `an` = 4'hF, `dp` = 1.
  - Prescaler = 0, digit index `idx` = 3, shadow = 16'h0000, `blank_q` = 0, blink phase = on, blink counter = 0.
- Prescaler: counts 0..DIV-1 and wraps. `tick` is asserted combinationally in the cycle where the prescaler equals DIV-1.
- On the tick edge:
  - `idx <= idx+1`, wrapping 3→0.
  - `an <= 4'hF` (blank cycle).
  - `blank_q <= 1`.
  - If `idx` == 3 (frame wrap), `shadow <= value`.
- On the edge where `blank_q` is 1:
  - `an <= ~(4'b1 << idx)`.
  - `seg <= decode(shadow[4*idx +: 4])`.
  - `blank_q <= 0`.
- `an`, `seg`, `dp` are registered outputs with no combinational path from inputs.
- Decode table (hex value → `seg`):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- `value` changes mid-frame have no effect until the next frame wrap.
- Reset asserted mid-frame returns every register to its reset value immediately, without waiting for a clock. The first tick after release wraps `idx` to 0 and captures `value`.

## Timing
- First digit after reset release: tick at cycle DIV-1 (counting from the first clock edge after release). Blank on that edge. Digit 0 is lit on the following edge.
- Each digit is lit for DIV-1 cycles and blanked for 1 cycle. A frame is 4·DIV cycles.
- Worst-case latency from a `value` change to a visible digit: 4·DIV + 2 cycles.
- `tick` and blink-toggle can occur on the same edge. Both take effect, and the new blink phase applies to the digit lit on the next edge.

## Configuration
- Macro: `SEVENSEG_BLINK_EN`.
- Defined:
  - A blink counter counts 0..BDIV-1. Each time it wraps, the blink phase toggles.
  - When `edit` = 1, the phase is off, and `idx` == `sel` at the lit edge, `seg` is loaded with 7'h7F. `an` is still driven normally.
  - `edit` and `sel` are sampled at the lit edge.
  - `edit` = 0 disables blanking regardless of phase.
- Undefined: no blink counter is built. `edit` and `sel` are ignored. The ports remain so the top level is unchanged.

## Structure
- `sevenseg_pkg`:
  - `NUM_DIGITS` = 4.
  - `SEG_OFF` = 7'h7F.
  - The 16-entry hex-to-segment constant table and a `hex2seg` function.
  - A `digit_idx_t` 2-bit typedef.
- Sub-module `tick_gen`:
  - Parameter `DIV`, port `tick` out.
  - Asynchronous active-high reset, counter resets to 0.
  - Instantiated once for refresh and once for blink (blink instance under the macro).

## Test plan
All cases use CLK_HZ=16, REFRESH_HZ=4 (DIV=4), BLINK_HZ=1 (BDIV=8).

- **Reset:** hold `reset`.
  - Required: `seg`=7F, `an`=F, `dp`=1.
  - After release with `value`=16'h1234: `an` is F for cycles 0–3, then E with `seg`=0x19 ('4'), then D/0x30, B/0x24, 7/0x79, each lit 3 cycles with a 1-cycle F gap.
- **Snapshot:** `value`=16'hA5F0, then change to 16'h0000 while digit 2 is lit.
  - Required: digit 3 still shows 0x08. The next frame shows 0x40 on all digits.
- **Decode sweep:** `value`=16'h89EF.
  - Required: `seg` sequence 0x0E, 0x06, 0x10, 0x00.
- **Async reset mid-frame:** assert `reset` between clock edges while digit 1 is lit.
  - Required: `an`=F and `seg`=7F with no clock edge needed.
  - After release, digit 0 is lit first.
- **Blink (macro defined):** `edit`=1, `sel`=2, `value`=16'h8888.
  - Required: digit 2 shows 0x7F while the blink phase is off, 0x00 while on. Other digits always show 0x00.
  - With `edit`=0, no digit blanks.
- **Macro undefined:** same stimulus as the blink case.
  - Required: all digits show 0x00 continuously.
